// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared constants and types for the DDS sweep controller.
package dds_sweep_ctrl_pkg;

  localparam logic [1:0] ADDR_FTW_START = 2'd0;
  localparam logic [1:0] ADDR_FTW_STEP  = 2'd1;
  localparam logic [1:0] ADDR_STEP_CNT  = 2'd2;
  localparam logic [1:0] ADDR_DWELL     = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } sweep_state_e;

  localparam int unsigned PIPE_DEPTH_DEFAULT = 14;

  // Phase-in to sin/cos latency of cordic_dds.
  function automatic int unsigned dds_lat(input int unsigned pipe_depth);
    return pipe_depth + 2;
  endfunction

  localparam int unsigned LAT = dds_lat(PIPE_DEPTH_DEFAULT);

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Host/DDS-facing signal bundle of the sweep controller.
interface dds_sweep_ctrl_if #(
  parameter int unsigned DW    = 16,
  parameter int unsigned ACC_W = 32
);
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [ACC_W-1:0] cfg_wdata;
  logic             start;
  logic             stop;
  logic             busy;
  logic             done;
  logic [DW-1:0]    phase_out;
  logic             phase_vld;
  logic             out_vld;
  logic [15:0]      tone_idx;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, stop,
    input  busy, done, phase_out, phase_vld, out_vld, tone_idx
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, stop,
    output busy, done, phase_out, phase_vld, out_vld, tone_idx
  );
endinterface

// File: rtl/dds_sweep_ctrl_vld_delay.sv
// Depth-stage 1-bit shift register that aligns the sweep valid flag with DDS outputs.
module dds_vld_delay #(
  parameter int unsigned Depth = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_i,
  output logic vld_o
);

  logic [Depth-1:0] sr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= vld_i;
      for (int i = 1; i < Depth; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign vld_o = sr_q[Depth-1];

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Phase accumulator plus stepped frequency-sweep FSM feeding cordic_dds.
// Define DDS_SWEEP_CONT_PHASE_EN to keep the accumulator across sweep starts.
module dds_sweep_ctrl
  import dds_sweep_ctrl_pkg::*;
#(
  parameter int unsigned DW         = 16,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned PIPE_DEPTH = 14
) (
  input logic              clk,
  input logic              rst_n,
  dds_sweep_ctrl_if.slave  ctrl_if
);

  localparam int unsigned Lat       = dds_lat(PIPE_DEPTH);
  localparam logic [15:0] DrainLast = 16'(Lat - 1);

  sweep_state_e     state_q, state_d;
  logic [ACC_W-1:0] ftw_start_q, ftw_start_d;
  logic [ACC_W-1:0] ftw_step_q, ftw_step_d;
  logic [15:0]      step_cnt_q, step_cnt_d;
  logic [15:0]      dwell_q, dwell_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ftw_q, ftw_d;
  logic [15:0]      tone_idx_q, tone_idx_d;
  logic [15:0]      dwell_cnt_q, dwell_cnt_d;
  logic [15:0]      drain_cnt_q, drain_cnt_d;
  logic [DW-1:0]    phase_q, phase_d;
  logic             done_q, done_d;
  logic             phase_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ftw_start_q <= '0;
      ftw_step_q  <= '0;
      step_cnt_q  <= '0;
      dwell_q     <= 16'd1;
      acc_q       <= '0;
      ftw_q       <= '0;
      tone_idx_q  <= '0;
      dwell_cnt_q <= '0;
      drain_cnt_q <= '0;
      phase_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ftw_start_q <= ftw_start_d;
      ftw_step_q  <= ftw_step_d;
      step_cnt_q  <= step_cnt_d;
      dwell_q     <= dwell_d;
      acc_q       <= acc_d;
      ftw_q       <= ftw_d;
      tone_idx_q  <= tone_idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      phase_q     <= phase_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ftw_start_d = ftw_start_q;
    ftw_step_d  = ftw_step_q;
    step_cnt_d  = step_cnt_q;
    dwell_d     = dwell_q;
    acc_d       = acc_q;
    ftw_d       = ftw_q;
    tone_idx_d  = tone_idx_q;
    dwell_cnt_d = dwell_cnt_q;
    drain_cnt_d = drain_cnt_q;
    phase_d     = phase_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ctrl_if.cfg_we) begin
          unique case (ctrl_if.cfg_addr)
            ADDR_FTW_START: ftw_start_d = ctrl_if.cfg_wdata;
            ADDR_FTW_STEP:  ftw_step_d  = ctrl_if.cfg_wdata;
            ADDR_STEP_CNT:  step_cnt_d  = ctrl_if.cfg_wdata[15:0];
            ADDR_DWELL:     dwell_d     = (ctrl_if.cfg_wdata[15:0] == 16'd0) ?
                                          16'd1 : ctrl_if.cfg_wdata[15:0];
            default: ;
          endcase
        end
        if (ctrl_if.start && !ctrl_if.stop) begin
          state_d     = StRun;
`ifdef DDS_SWEEP_CONT_PHASE_EN
          acc_d       = acc_q;
`else
          acc_d       = '0;
`endif
          ftw_d       = ftw_start_q;
          tone_idx_d  = '0;
          dwell_cnt_d = dwell_q - 16'd1;
        end
      end
      StRun: begin
        acc_d   = acc_q + ftw_q;
        phase_d = acc_q[ACC_W-1 -: DW];
        if (ctrl_if.stop) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end else if (dwell_cnt_q != 16'd0) begin
          dwell_cnt_d = dwell_cnt_q - 16'd1;
        end else if (tone_idx_q < step_cnt_q) begin
          ftw_d       = ftw_q + ftw_step_q;
          tone_idx_d  = tone_idx_q + 16'd1;
          dwell_cnt_d = dwell_q - 16'd1;
        end else begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end
      end
      StDrain: begin
        // Hold off IDLE until the last valid phase has left the DDS pipeline.
        if (drain_cnt_q == DrainLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign phase_vld         = (state_q == StRun);
  assign ctrl_if.phase_vld = phase_vld;
  assign ctrl_if.busy      = (state_q != StIdle);
  assign ctrl_if.done      = done_q;
  assign ctrl_if.tone_idx  = tone_idx_q;
  assign ctrl_if.phase_out = phase_vld ? acc_q[ACC_W-1 -: DW] : phase_q;

  dds_vld_delay #(
    .Depth (Lat)
  ) u_vld_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (phase_vld),
    .vld_o (ctrl_if.out_vld)
  );

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl with a phase/tone scoreboard.
module tb_dds_sweep_ctrl;
  import dds_sweep_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.DW(16), .ACC_W(32)) bus ();

  dds_sweep_ctrl #(
    .DW         (16),
    .ACC_W      (32),
    .PIPE_DEPTH (14)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Entry layout: {tone_idx, phase_out}.
  logic [31:0] exp_q[$];
  logic [31:0] model_acc = '0;
  logic [31:0] mon_e;

  int cyc = 0;
  int vld_cnt, ov_cnt, done_cnt, first_vld, last_vld, first_ov, done_cyc;
  logic done_ov, done_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.phase_vld) begin
      vld_cnt++;
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
      if (exp_q.size() == 0) begin
        chk("vld_unexpected", 32'(bus.phase_vld), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("phase", 32'(bus.phase_out), 32'(mon_e[15:0]));
        chk("tone", 32'(bus.tone_idx), 32'(mon_e[31:16]));
      end
    end
    if (bus.out_vld) begin
      ov_cnt++;
      if (first_ov < 0) first_ov = cyc;
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_ov   = bus.out_vld;
      done_busy = bus.busy;
    end
  end

  task automatic clear_stats();
    vld_cnt = 0; ov_cnt = 0; done_cnt = 0;
    first_vld = -1; last_vld = -1; first_ov = -1; done_cyc = -1;
    done_ov = 1'b0; done_busy = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.cfg_we = 1'b1; bus.cfg_addr = addr; bus.cfg_wdata = data;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic push_model(input logic [31:0] fs, input logic [31:0] fstep,
                            input int cnt, input int dw, input int n);
    logic [31:0] ftw;
    logic [15:0] tone;
`ifndef DDS_SWEEP_CONT_PHASE_EN
    model_acc = '0;
`endif
    ftw = fs;
    tone = '0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({tone, model_acc[31:16]});
      model_acc = model_acc + ftw;
      if ((i + 1) % dw == 0 && int'(tone) < cnt) begin
        ftw = ftw + fstep;
        tone = tone + 16'd1;
      end
    end
  endtask

  task automatic start_pulse();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // stop_at: RUN cycle (1..4) carrying stop, 0 for none. poke: write FTW_START
  // in RUN cycle 2 and, with stop_at set, pulse start in the first DRAIN cycle.
  task automatic sweep(input logic [31:0] fs, input logic [31:0] fstep, input int cnt,
                       input int dw, input int stop_at, input bit do_cfg, input bit poke);
    int n;
    if (do_cfg) begin
      cfg_write(ADDR_FTW_START, fs);
      cfg_write(ADDR_FTW_STEP, fstep);
      cfg_write(ADDR_STEP_CNT, 32'(cnt));
      cfg_write(ADDR_DWELL, 32'(dw));
    end
    n = (stop_at > 0) ? stop_at : (cnt + 1) * dw;
    clear_stats();
    push_model(fs, fstep, cnt, dw, n);
    start_pulse();
    for (int c = 1; c <= 4; c++) begin
      bus.stop      = (c == stop_at);
      bus.cfg_we    = poke && (c == 2);
      bus.cfg_addr  = ADDR_FTW_START;
      bus.cfg_wdata = 32'hDEAD_0000;
      bus.start     = poke && (stop_at != 0) && (c == 4);
      @(posedge clk); #1;
    end
    bus.stop = 1'b0; bus.cfg_we = 1'b0; bus.start = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done_cnt != 0) break;
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("vld_cnt", 32'(vld_cnt), 32'(n));
    chk("model_drained", 32'(exp_q.size()), 32'd0);
    chk("out_vld_lag", 32'(first_ov - first_vld), 32'(LAT));
    chk("out_vld_cnt", 32'(ov_cnt), 32'(n));
    chk("done_lag", 32'(done_cyc - last_vld), 32'(LAT + 1));
    chk("done_out_vld", 32'(done_ov), 32'd0);
    chk("done_busy", 32'(done_busy), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
    clear_stats();
    #12;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_phase", 32'(bus.phase_out), 32'd0);
    chk("rst_phase_vld", 32'(bus.phase_vld), 32'd0);
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_tone", 32'(bus.tone_idx), 32'd0);
    #11 rst_n = 1'b1;

    sweep(32'h0100_0000, 32'h0, 0, 8, 0, 1'b1, 1'b0);
    sweep(32'h0100_0000, 32'h0100_0000, 2, 4, 0, 1'b1, 1'b0);
    sweep(32'hF000_0000, 32'hF000_0000, 1, 3, 0, 1'b1, 1'b0);
    // Abort with busy-time config write and a start during DRAIN.
    sweep(32'h0200_0000, 32'h0, 0, 10, 3, 1'b1, 1'b1);
    // Same registers: the busy-time FTW_START write must have been dropped.
    sweep(32'h0200_0000, 32'h0, 0, 10, 0, 1'b0, 1'b0);

    @(posedge clk); #1;
    bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    @(negedge clk);
    chk("startstop_busy", 32'(bus.busy), 32'd0);
    chk("startstop_vld", 32'(bus.phase_vld), 32'd0);

    // Asynchronous reset in the middle of a long tone.
    cfg_write(ADDR_STEP_CNT, 32'd0);
    cfg_write(ADDR_DWELL, 32'd40);
    clear_stats();
    push_model(32'h0200_0000, 32'h0, 0, 40, 40);
    start_pulse();
    repeat (20) @(negedge clk);
    chk("pre_rst_out_vld", 32'(bus.out_vld), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_phase_vld", 32'(bus.phase_vld), 32'd0);
    chk("arst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("arst_phase", 32'(bus.phase_out), 32'd0);
    exp_q.delete();
    model_acc = '0;
    clear_stats();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("arst_no_done", 32'(done_cnt), 32'd0);

    // Register reset values: FTW_START=0, STEP_CNT=0, DWELL=1.
    sweep(32'h0, 32'h0, 0, 1, 0, 1'b0, 1'b0);
    // DWELL write of 0 is stored as 1.
    cfg_write(ADDR_FTW_START, 32'h1000_0000);
    cfg_write(ADDR_STEP_CNT, 32'd2);
    cfg_write(ADDR_DWELL, 32'd0);
    sweep(32'h1000_0000, 32'h0, 2, 1, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
